// File: rtl/pga_pkg.sv
// Shared definitions for the PGA serial engine and its offset auto-calibration sequencer.
package pga_pkg;

    localparam int OFFSET_W = 5;
    localparam int GAIN_W   = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL,
        S_MEAS,
        S_MEAS_W,
        S_TRIAL,
        S_TRIAL_W,
        S_SETTLE,
        S_DECIDE,
        S_GAIN,
        S_GAIN_W,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    // One SAR decision: drop the bit under test unless the comparator asks for a
    // higher code, then raise the next lower bit as the following trial.
    function automatic logic [OFFSET_W-1:0] sar_step(
        input logic [OFFSET_W-1:0] code,
        input logic [2:0]          bit_idx,
        input logic                keep
    );
        logic [OFFSET_W-1:0] c;
        c = code;
        if (!keep) begin
            c[bit_idx] = 1'b0;
        end
        if (bit_idx != 3'd0) begin
            c[bit_idx - 3'd1] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pga_wait_timer.sv
// Loadable down-counter; expired is high whenever the count has reached zero.
module pga_wait_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expired = (cnt_reg == '0);

endmodule

// File: rtl/pga_autocal_seq.sv
// Offset auto-calibration sequencer: per channel enters Vos measure mode, runs a
// 5-step SAR trim against the offset comparator, then programs the target gain.
module pga_autocal_seq
    import pga_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SETTLE_CYC = 250,
    parameter int OP_TIMEOUT = 4096
) (
    input  logic                   clk25,
    input  logic                   wb_rst,
    input  logic                   start,
    input  logic [4*N_CH-1:0]      gain_cfg,
    input  logic                   cmp_in,
    input  logic                   op_complete,
    output logic                   set_vos,
    output logic                   set_gain,
    output logic                   set_measure,
    output logic [OFFSET_W-1:0]    offset,
    output logic [GAIN_W-1:0]      gain,
    output logic [N_CH-1:0]        ch_sel,
    output logic [5*N_CH-1:0]      cal_offset,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [2:0]             err_ch
);

    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int T_MAX = (OP_TIMEOUT > SETTLE_CYC) ? OP_TIMEOUT : SETTLE_CYC;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [OFFSET_W-1:0] CODE_MSB = {1'b1, {(OFFSET_W-1){1'b0}}};

    state_t                 state_reg, state_next;
    logic [2:0]             ch_reg;
    logic [CW-1:0]          ch_idx;
    logic                   last_ch;
    logic [OFFSET_W-1:0]    code_reg;
    logic [2:0]             bit_idx_reg;
    logic [GAIN_W*N_CH-1:0] gain_lat_reg;
    logic                   err_reg;
    logic [2:0]             err_ch_reg;
    logic                   cmp_meta_reg, cmp_sync_reg;
    logic                   start_accept;
    logic                   in_wait;
    logic                   op_timeout;
    logic                   tmr_load;
    logic [TW-1:0]          tmr_val;
    logic                   tmr_expired;

    assign ch_idx       = ch_reg[CW-1:0];
    assign last_ch      = (ch_reg == 3'(N_CH - 1));
    assign start_accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                    (state_reg == S_ERR));
    assign in_wait      = (state_reg == S_MEAS_W) || (state_reg == S_TRIAL_W) ||
                          (state_reg == S_GAIN_W);
    assign op_timeout   = in_wait && !op_complete && tmr_expired;

    // Comparator is asynchronous to clk25; only the second flop is ever used.
    always_ff @(posedge clk25) begin
        if (wb_rst) begin
            cmp_meta_reg <= 1'b0;
            cmp_sync_reg <= 1'b0;
        end else begin
            cmp_meta_reg <= cmp_in;
            cmp_sync_reg <= cmp_meta_reg;
        end
    end

    always_ff @(posedge clk25) begin
        if (wb_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start_accept) state_next = S_SEL;
            S_SEL:     state_next = S_MEAS;
            S_MEAS:    state_next = S_MEAS_W;
            S_MEAS_W:  if (op_complete) state_next = S_TRIAL;
                       else if (op_timeout) state_next = S_ERR;
            S_TRIAL:   state_next = S_TRIAL_W;
            S_TRIAL_W: if (op_complete) state_next = S_SETTLE;
                       else if (op_timeout) state_next = S_ERR;
            S_SETTLE:  if (tmr_expired) state_next = S_DECIDE;
            S_DECIDE:  state_next = (bit_idx_reg != 3'd0) ? S_TRIAL : S_GAIN;
            S_GAIN:    state_next = S_GAIN_W;
            S_GAIN_W:  if (op_complete) state_next = S_NEXT;
                       else if (op_timeout) state_next = S_ERR;
            S_NEXT:    state_next = last_ch ? S_DONE : S_SEL;
            S_DONE:    state_next = start_accept ? S_SEL : S_IDLE;
            S_ERR:     state_next = start_accept ? S_SEL : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // The shared timer is armed with the op timeout on every pulse and
    // re-armed with the settle time once the Vos write has completed.
    always_comb begin
        set_measure = (state_reg == S_MEAS);
        set_vos     = (state_reg == S_TRIAL);
        set_gain    = (state_reg == S_GAIN);
        done        = (state_reg == S_DONE);
        busy        = !((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                        (state_reg == S_ERR));
        tmr_load    = 1'b0;
        tmr_val     = TW'(OP_TIMEOUT - 1);
        if ((state_reg == S_MEAS) || (state_reg == S_TRIAL) || (state_reg == S_GAIN)) begin
            tmr_load = 1'b1;
        end else if ((state_reg == S_TRIAL_W) && op_complete) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(SETTLE_CYC - 1);
        end
    end

    always_ff @(posedge clk25) begin
        if (wb_rst) begin
            ch_reg       <= '0;
            code_reg     <= '0;
            bit_idx_reg  <= '0;
            gain_lat_reg <= '0;
            err_reg      <= 1'b0;
            err_ch_reg   <= '0;
        end else if (start_accept) begin
            ch_reg       <= '0;
            code_reg     <= '0;
            bit_idx_reg  <= 3'd4;
            gain_lat_reg <= gain_cfg;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_MEAS_W: begin
                    if (op_complete) begin
                        code_reg    <= CODE_MSB;
                        bit_idx_reg <= 3'd4;
                    end
                end
                S_DECIDE: begin
                    code_reg <= sar_step(code_reg, bit_idx_reg, cmp_sync_reg);
                    if (bit_idx_reg != 3'd0) begin
                        bit_idx_reg <= bit_idx_reg - 3'd1;
                    end
                end
                S_NEXT: begin
                    if (!last_ch) begin
                        ch_reg   <= ch_reg + 3'd1;
                        code_reg <= '0;
                    end
                end
                default: ;
            endcase
            if (op_timeout) begin
                err_reg    <= 1'b1;
                err_ch_reg <= ch_reg;
            end
        end
    end

    // Per-channel result registers survive an aborted sequence untouched.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [OFFSET_W-1:0] cal_reg;

            always_ff @(posedge clk25) begin
                if (wb_rst) begin
                    cal_reg <= '0;
                end else if ((state_reg == S_GAIN) && (ch_idx == CW'(gi))) begin
                    cal_reg <= code_reg;
                end
            end

            assign cal_offset[5*gi +: 5] = cal_reg;
            assign ch_sel[gi]            = busy && (ch_idx == CW'(gi));
        end
    endgenerate

    always_comb begin
        gain = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_idx == CW'(i)) begin
                gain = gain_lat_reg[GAIN_W*i +: GAIN_W];
            end
        end
    end

    assign offset = code_reg;
    assign err    = err_reg;
    assign err_ch = err_ch_reg;

    pga_wait_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk25),
        .srst     (wb_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

endmodule
